// File: rtl/v_noc_pkg.sv
// Shared types and widths for the v_sender traffic injector.
// ENABLE_TXN_ID adds a transaction id to each sent-flit record.
package v_noc_pkg;

  localparam int FLIT_LENGTH      = 256;
  localparam int FLIT_DATA_LENGTH = 64;
  localparam int VC_ID_NUM_MAX_W  = 2;
  localparam int NODE_ID_W        = 4;
  localparam int IO_PORT_W        = 3;
  localparam int V_SENDER_GAP_W   = 8;
  localparam int TXN_ID_W         = 8;

  typedef logic [FLIT_LENGTH-1:0] flit_payload_t;
  typedef logic [NODE_ID_W-1:0]   node_id_t;

  typedef enum logic [IO_PORT_W-1:0] {
    IO_N = 3'd0,
    IO_S = 3'd1,
    IO_E = 3'd2,
    IO_W = 3'd3,
    IO_L = 3'd4
  } io_port_t;

  typedef struct packed {
    node_id_t                    src_id;
    logic [FLIT_DATA_LENGTH-1:0] flit_data;
`ifdef ENABLE_TXN_ID
    logic [TXN_ID_W-1:0]         txn_id;
`endif
  } sender_info_t;

  localparam int SENDER_INFO_W = $bits(sender_info_t);

  // Round-robin pointer advance: one past the granted VC, wrapping at vc_num.
  function automatic logic [VC_ID_NUM_MAX_W-1:0] vc_next(
    input logic [VC_ID_NUM_MAX_W-1:0] idx,
    input int                         vc_num
  );
    return (int'(idx) >= vc_num - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/v_sender_vc_rr_arb.sv
// N-way round-robin VC arbiter: grants the lowest requesting index at or
// above ptr, wrapping around to index 0. Purely combinational.
module v_sender_vc_rr_arb #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int cand;

  // Scan from ptr upward with wrap and keep the first requester found.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (!grant_vld && req[cand]) begin
        grant_vld      = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/v_sender.sv
// Traffic injector for one router inport: takes flits from a generator,
// picks a VC with free credit round-robin, launches the flit registered one
// cycle later and logs it to the scoreboard. Credits come back from the DUT.
// Optional feature macro: V_SENDER_INJ_GAP_EN enables inj_gap_i throttling.
module v_sender
  import v_noc_pkg::*;
#(
  parameter  int VC_NUM   = 4,
  parameter  int VC_DEPTH = 2,
  localparam int CRD_W    = $clog2(VC_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       gen_vld_i,
  output logic                       gen_rdy_o,
  input  logic [FLIT_LENGTH-1:0]     gen_flit_i,
  input  logic [IO_PORT_W-1:0]       gen_look_ahead_routing_i,
  input  logic [VC_NUM-1:0]          gen_vc_mask_i,
  input  logic [V_SENDER_GAP_W-1:0]  inj_gap_i,
  output logic                       tx_flit_pend_o,
  output logic                       tx_flit_v_o,
  output logic [FLIT_LENGTH-1:0]     tx_flit_o,
  output logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o,
  output logic [IO_PORT_W-1:0]       tx_flit_look_ahead_routing_o,
  input  logic                       tx_lcrd_v_i,
  input  logic [VC_ID_NUM_MAX_W-1:0] tx_lcrd_id_i,
  output logic                       sent_vld_o,
  output logic [SENDER_INFO_W-1:0]   sent_o,
  input  logic                       sent_rdy_i,
  input  logic [NODE_ID_W-1:0]       node_id_i,
  output logic                       crd_err_o,
  output logic [31:0]                flits_sent_o
);

  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(VC_DEPTH);

  logic [CRD_W-1:0]           crd [VC_NUM];
  logic [VC_NUM-1:0]          elig;
  logic [VC_NUM-1:0]          grant_oh;
  logic [VC_NUM-1:0]          consume;
  logic [VC_NUM-1:0]          ret_hit;
  logic [VC_NUM-1:0]          crd_ovf;
  logic [VC_ID_NUM_MAX_W-1:0] rr_ptr;
  logic [VC_ID_NUM_MAX_W-1:0] grant_idx;
  logic                       grant_vld;
  logic                       gap_ok;
  logic                       accept;
  logic                       id_bad;
  sender_info_t               info;

  // A VC is eligible when the flit may use it and it still holds a credit.
  always_comb begin
    elig = '0;
    for (int v = 0; v < VC_NUM; v++) begin
      elig[v] = gen_vc_mask_i[v] && (crd[v] != '0);
    end
  end

  v_sender_vc_rr_arb #(
    .N     (VC_NUM),
    .IDX_W (VC_ID_NUM_MAX_W)
  ) u_arb (
    .req       (elig),
    .ptr       (rr_ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  // Handshake: grant_vld is the OR of all eligible VCs.
  always_comb begin
    gen_rdy_o      = !rst && grant_vld && sent_rdy_i && gap_ok;
    accept         = gen_vld_i && gen_rdy_o;
    consume        = accept ? grant_oh : '0;
    tx_flit_pend_o = accept;
    sent_vld_o     = accept;
  end

  // Decode credit returns; a return that would push a VC past VC_DEPTH is
  // an overflow unless the same VC is being consumed this cycle.
  always_comb begin
    ret_hit = '0;
    crd_ovf = '0;
    id_bad  = tx_lcrd_v_i && (int'(tx_lcrd_id_i) >= VC_NUM);
    for (int v = 0; v < VC_NUM; v++) begin
      ret_hit[v] = tx_lcrd_v_i && (int'(tx_lcrd_id_i) == v);
      crd_ovf[v] = ret_hit[v] && !consume[v] && (crd[v] == CRD_MAX);
    end
  end

  // Per-VC credit counters; return and consume in one cycle cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int v = 0; v < VC_NUM; v++) crd[v] <= CRD_MAX;
    end else begin
      for (int v = 0; v < VC_NUM; v++) begin
        if (ret_hit[v] && !consume[v] && (crd[v] != CRD_MAX)) begin
          crd[v] <= crd[v] + 1'b1;
        end else if (consume[v] && !ret_hit[v]) begin
          crd[v] <= crd[v] - 1'b1;
        end
      end
    end
  end

  // Round-robin pointer moves just past each granted VC.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= vc_next(grant_idx, VC_NUM);
    end
  end

  // Launch register: the accepted flit goes out on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_flit_v_o                  <= 1'b0;
      tx_flit_o                    <= '0;
      tx_flit_vc_id_o              <= '0;
      tx_flit_look_ahead_routing_o <= '0;
    end else begin
      tx_flit_v_o <= accept;
      if (accept) begin
        tx_flit_o                    <= gen_flit_i;
        tx_flit_vc_id_o              <= grant_idx;
        tx_flit_look_ahead_routing_o <= gen_look_ahead_routing_i;
      end
    end
  end

  // Sticky credit error plus a wrapping count of launched flits.
  always_ff @(posedge clk) begin
    if (rst) begin
      crd_err_o    <= 1'b0;
      flits_sent_o <= '0;
    end else begin
      if (id_bad || (|crd_ovf)) crd_err_o <= 1'b1;
      if (tx_flit_v_o) flits_sent_o <= flits_sent_o + 32'd1;
    end
  end

`ifdef ENABLE_TXN_ID
  logic [TXN_ID_W-1:0] txn_cnt;

  // Transaction ids number accepted flits in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_cnt <= '0;
    end else if (accept) begin
      txn_cnt <= txn_cnt + 1'b1;
    end
  end
`endif

  // Scoreboard record: source node and the top data field of the flit.
  always_comb begin
    info           = '0;
    info.src_id    = node_id_i;
    info.flit_data = gen_flit_i[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH];
`ifdef ENABLE_TXN_ID
    info.txn_id    = txn_cnt;
`endif
    sent_o         = info;
  end

`ifdef V_SENDER_INJ_GAP_EN
  logic [V_SENDER_GAP_W-1:0] gap_cnt;

  // Idle-gap throttle: reload on each accept, count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (accept) begin
      gap_cnt <= inj_gap_i;
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  assign gap_ok = (gap_cnt == '0);
`else
  logic unused_inj_gap;

  assign gap_ok         = 1'b1;
  assign unused_inj_gap = ^inj_gap_i;
`endif

endmodule

// File: tb/tb_v_sender.sv
// Bench for v_sender: a per-cycle vector table checks handshake, errors and
// counters while a queue of expected launches is matched against tx_flit_*.
module tb_v_sender;
  import v_noc_pkg::*;

  localparam int VC_NUM   = 4;
  localparam int VC_DEPTH = 2;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       gen_vld;
  logic                       gen_rdy_o;
  logic [FLIT_LENGTH-1:0]     gen_flit;
  logic [IO_PORT_W-1:0]       gen_route;
  logic [VC_NUM-1:0]          gen_mask;
  logic [V_SENDER_GAP_W-1:0]  inj_gap;
  logic                       tx_flit_pend_o;
  logic                       tx_flit_v_o;
  logic [FLIT_LENGTH-1:0]     tx_flit_o;
  logic [VC_ID_NUM_MAX_W-1:0] tx_flit_vc_id_o;
  logic [IO_PORT_W-1:0]       tx_route_o;
  logic                       lcrd_v;
  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id;
  logic                       sent_vld_o;
  logic [SENDER_INFO_W-1:0]   sent_o;
  logic                       sent_rdy;
  logic [NODE_ID_W-1:0]       node_id;
  logic                       crd_err_o;
  logic [31:0]                flits_sent_o;

  always #5 clk = ~clk;

  v_sender #(.VC_NUM(VC_NUM), .VC_DEPTH(VC_DEPTH)) dut (
    .clk                          (clk),
    .rst                          (rst),
    .gen_vld_i                    (gen_vld),
    .gen_rdy_o                    (gen_rdy_o),
    .gen_flit_i                   (gen_flit),
    .gen_look_ahead_routing_i     (gen_route),
    .gen_vc_mask_i                (gen_mask),
    .inj_gap_i                    (inj_gap),
    .tx_flit_pend_o               (tx_flit_pend_o),
    .tx_flit_v_o                  (tx_flit_v_o),
    .tx_flit_o                    (tx_flit_o),
    .tx_flit_vc_id_o              (tx_flit_vc_id_o),
    .tx_flit_look_ahead_routing_o (tx_route_o),
    .tx_lcrd_v_i                  (lcrd_v),
    .tx_lcrd_id_i                 (lcrd_id),
    .sent_vld_o                   (sent_vld_o),
    .sent_o                       (sent_o),
    .sent_rdy_i                   (sent_rdy),
    .node_id_i                    (node_id),
    .crd_err_o                    (crd_err_o),
    .flits_sent_o                 (flits_sent_o)
  );

  typedef struct {
    logic       rst;
    logic       vld;
    logic [3:0] mask;
    logic       lv;
    logic [1:0] lid;
    logic       srdy;
    logic       exp_rdy;
    logic [1:0] exp_vc;
    logic       exp_err;
    int         exp_sent;
  } vec_t;

  typedef struct {
    logic [FLIT_LENGTH-1:0] flit;
    logic [1:0]             vc;
    logic [IO_PORT_W-1:0]   route;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic r, input logic vld, input logic [3:0] mask,
                              input logic lv, input logic [1:0] lid, input logic srdy,
                              input logic exp_rdy, input logic [1:0] exp_vc,
                              input logic exp_err, input int exp_sent);
    vec_t v;
    v.rst = r; v.vld = vld; v.mask = mask; v.lv = lv; v.lid = lid; v.srdy = srdy;
    v.exp_rdy = exp_rdy; v.exp_vc = exp_vc; v.exp_err = exp_err; v.exp_sent = exp_sent;
    return v;
  endfunction

  // Drive one cycle of inputs just after the edge; queue the expected launch.
  task automatic applyStimulus(input vec_t v);
    logic [FLIT_LENGTH-1:0] f;
    logic [IO_PORT_W-1:0]   r;
    exp_t                   e;
    f = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    r = IO_PORT_W'($urandom_range(0, 4));
    @(posedge clk);
    #1;
    rst = v.rst; gen_vld = v.vld; gen_mask = v.mask;
    lcrd_v = v.lv; lcrd_id = v.lid; sent_rdy = v.srdy;
    gen_flit = f; gen_route = r;
    if (v.vld && v.exp_rdy) begin
      e.flit = f; e.vc = v.exp_vc; e.route = r;
      sb.push_back(e);
    end
  endtask

  // Mid-cycle checks of the handshake, record, error flag and counter.
  task automatic checkRow(input vec_t v, input int idx);
    string tag;
    @(negedge clk);
    tag = $sformatf("row%0d", idx);
    checkOutput({tag, "_gen_rdy"}, 256'(gen_rdy_o), 256'(v.exp_rdy));
    checkOutput({tag, "_sent_vld"}, 256'(sent_vld_o), 256'(v.vld && v.exp_rdy));
    checkOutput({tag, "_pend"}, 256'(tx_flit_pend_o), 256'(v.vld && v.exp_rdy));
    checkOutput({tag, "_crd_err"}, 256'(crd_err_o), 256'(v.exp_err));
    if (v.vld && v.exp_rdy)
      checkOutput({tag, "_sent_o"}, 256'(sent_o[SENDER_INFO_W-1 -: NODE_ID_W+FLIT_DATA_LENGTH]),
                  256'({node_id, gen_flit[FLIT_LENGTH-1 -: FLIT_DATA_LENGTH]}));
    if (v.exp_sent >= 0)
      checkOutput({tag, "_flits_sent"}, 256'(flits_sent_o), 256'(v.exp_sent));
  endtask

  // Every launched flit must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (tx_flit_v_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("[TB] FAIL unexpected_flit: got vc %0d expected no flit", tx_flit_vc_id_o);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("tx_flit", tx_flit_o, mon_e.flit);
        checkOutput("tx_vc", 256'(tx_flit_vc_id_o), 256'(mon_e.vc));
        checkOutput("tx_route", 256'(tx_route_o), 256'(mon_e.route));
      end
    end
  end

  initial begin
    vec_t v;
    int   k;
    rst = 1'b1; gen_vld = 1'b1; gen_mask = 4'hF; inj_gap = '0;
    lcrd_v = 1'b0; lcrd_id = '0; sent_rdy = 1'b1; node_id = 4'hA;
    gen_flit = '0; gen_route = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_gen_rdy", 256'(gen_rdy_o), 256'(0));
    checkOutput("rst_sent_vld", 256'(sent_vld_o), 256'(0));
    checkOutput("rst_pend", 256'(tx_flit_pend_o), 256'(0));
    checkOutput("rst_tx_v", 256'(tx_flit_v_o), 256'(0));
    checkOutput("rst_tx_flit", tx_flit_o, 256'(0));
    checkOutput("rst_tx_vc", 256'(tx_flit_vc_id_o), 256'(0));
    checkOutput("rst_crd_err", 256'(crd_err_o), 256'(0));
    checkOutput("rst_flits_sent", 256'(flits_sent_o), 256'(0));

    // Single VC, depth 2: two flits go, third stalls until a credit returns.
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0001, 1, 0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0001, 0, 0, 1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 0, 4'b0001, 0, 0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, -1));
    // All four VCs: strict rotation, one flit per clock until credits run out.
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 1, 2'(i % 4), 0, (i == 0) ? 0 : -1));
    tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 1, 0, 0, 0, 7));
    tbl.push_back(mk(0, 0, 4'b1111, 0, 0, 1, 0, 0, 0, 8));
    // VC1 with simultaneous return and consume at zero and at one credit.
    tbl.push_back(mk(0, 1, 4'b0010, 1, 1, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 1, 1, 1, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 0, 4'b0010, 1, 1, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 1, 1, 1, 1, 1, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 1, 1, 1, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 1, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 1, 1, 0, 0, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0010, 0, 0, 1, 1, 1, 0, -1));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1, 0, 0, 0, -1));
    // Overflow on VC2: sticky error, counter held at depth, cleared by reset.
    tbl.push_back(mk(0, 0, 4'b0100, 1, 2, 1, 1, 0, 0, -1));
    tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 1, 1, 2, 1, -1));
    tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 1, 1, 2, 1, -1));
    tbl.push_back(mk(0, 1, 4'b0100, 0, 0, 1, 0, 0, 1, -1));
    tbl.push_back(mk(0, 1, 4'b1111, 0, 0, 0, 0, 0, 1, -1));
    tbl.push_back(mk(1, 0, 4'b0000, 0, 0, 1, 0, 0, 1, -1));
    tbl.push_back(mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkRow(tbl[i], i);
    end

    // Continuous offer with inj_gap_i=3: throttled to every 4th cycle only
    // when the gap feature is built in.
    inj_gap = 8'd3;
    k = 0;
    for (int i = 0; i < 8; i++) begin
`ifdef V_SENDER_INJ_GAP_EN
      v = mk(0, 1, 4'b1111, 0, 0, 1, (i % 4) == 0, 2'(k % 4), 0, -1);
`else
      v = mk(0, 1, 4'b1111, 0, 0, 1, 1, 2'(k % 4), 0, -1);
`endif
      if (v.exp_rdy) k++;
      applyStimulus(v);
      checkRow(v, 100 + i);
    end
    v = mk(0, 0, 4'b0000, 0, 0, 1, 0, 0, 0, -1);
    applyStimulus(v);
    inj_gap = '0;
    checkRow(v, 108);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 256'(sb.size()), 256'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
